// File: rtl/key_schedule_seq.sv
// DES key schedule, one 48-bit round key per handshake, K1..K16 or K16..K1.
// Ports: clk/rstn (sync, active-high), key_i/key_valid_i/decrypt_i/key_ready_o in;
//        rk_o/rk_idx_o/rk_valid_o/rk_ready_i/rk_last_o out; parity_err_o pulse.

module p_box_56_48 (
   input  logic [55:0] din,
   output logic [47:0] dout
);
   // PC-2, FIPS numbering: output bit 1 is dout[47], input bit 1 is din[55]
   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   always_comb begin
      dout = '0;
      for (int i = 0; i < 48; i++) begin
         dout[47-i] = din[56-PC2[i]];
      end
   end
endmodule

module key_schedule_seq #(
   parameter int PARITY_CHECK = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] key_i,
   input  logic        key_valid_i,
   input  logic        decrypt_i,
   output logic        key_ready_o,
   output logic [47:0] rk_o,
   output logic [3:0]  rk_idx_o,
   output logic        rk_valid_o,
   input  logic        rk_ready_i,
   output logic        rk_last_o,
   output logic        parity_err_o
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   // PC-1, FIPS numbering: key bit 1 is key_i[63], output bit 1 is pc1[55]
   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   logic [0:0]  state_q, state_d;
   logic [55:0] cd_q, cd_d;
   logic [3:0]  n_q, n_d;
   logic        dec_q, dec_d;
   logic        perr_q, perr_d;

   logic [55:0] pc1;
   logic [7:0]  byte_odd;
   logic        parity_bad;
   logic        accept;
   logic        hs;
   logic        one_shift;

   function automatic logic [27:0] rotl28(input logic [27:0] x,
                                          input logic one);
      return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x,
                                          input logic one);
      return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   always_comb begin
      pc1 = '0;
      for (int i = 0; i < 56; i++) begin
         pc1[55-i] = key_i[64-PC1[i]];
      end
      byte_odd = '0;
      for (int b = 0; b < 8; b++) begin
         byte_odd[b] = ^key_i[8*b +: 8];
      end
   end

   assign parity_bad = (PARITY_CHECK != 0) && (byte_odd != 8'hFF);
   assign accept     = (state_q == IDLE) && key_valid_i;
   assign hs         = (state_q == RUN) && rk_ready_i;
   // Rounds 2, 9 and 16 use a single-bit shift; both directions hit them
   // at the same handshake counts.
   assign one_shift  = (n_q == 4'd0) || (n_q == 4'd7) || (n_q == 4'd14);

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      n_d     = n_q;
      dec_d   = dec_q;
      perr_d  = 1'b0;
      if (accept) begin
         if (parity_bad) begin
            perr_d = 1'b1;
         end else begin
            // Decrypt starts at C16D16, which equals PC-1 (total shift 28)
            cd_d    = decrypt_i ? pc1
                    : {rotl28(pc1[55:28], 1'b1), rotl28(pc1[27:0], 1'b1)};
            n_d     = 4'd0;
            dec_d   = decrypt_i;
            state_d = RUN;
         end
      end else if (hs) begin
         n_d = n_q + 4'd1;
         if (n_q == 4'd15) begin
            state_d = IDLE;
         end else if (dec_q) begin
            cd_d = {rotr28(cd_q[55:28], one_shift),
                    rotr28(cd_q[27:0], one_shift)};
         end else begin
            cd_d = {rotl28(cd_q[55:28], one_shift),
                    rotl28(cd_q[27:0], one_shift)};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= IDLE;
         cd_q    <= '0;
         n_q     <= '0;
         dec_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         n_q     <= n_d;
         dec_q   <= dec_d;
         perr_q  <= perr_d;
      end
   end

   p_box_56_48 u_pc2 (
      .din  (cd_q),
      .dout (rk_o)
   );

   assign key_ready_o  = (state_q == IDLE);
   assign rk_valid_o   = (state_q == RUN);
   assign rk_idx_o     = dec_q ? (4'd15 - n_q) : n_q;
   assign rk_last_o    = (state_q == RUN) && (n_q == 4'd15);
   assign parity_err_o = (PARITY_CHECK != 0) && perr_q;
endmodule

// File: tb/tb_key_schedule_seq.sv
// Scoreboard bench for key_schedule_seq: parity-checking and plain instances.
// Expected round keys come from the FIPS worked example for 133457799BBCDFF1.

module tb_key_schedule_seq;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [63:0] key = '0;
   logic        kv = 1'b0;
   logic        dec = 1'b0;
   logic        kr;
   logic [47:0] rk;
   logic [3:0]  idx;
   logic        rv;
   logic        rr = 1'b1;
   logic        last;
   logic        perr;

   logic [63:0] z_key = '0;
   logic        z_kv = 1'b0;
   logic        z_dec = 1'b0;
   logic        z_kr;
   logic [47:0] z_rk;
   logic [3:0]  z_idx;
   logic        z_rv;
   logic        z_last;
   logic        z_perr;

   int n_cmp = 0;
   int n_err = 0;
   logic mon_en = 1'b0;

   logic [47:0] ks [0:15];
   logic [52:0] q1 [$];
   logic [52:0] q0 [$];

   localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
   localparam logic [63:0] KBAD = 64'h133457799BBCDFF0;

   always #5 clk = ~clk;

   key_schedule_seq #(.PARITY_CHECK(1)) dut (
      .clk(clk), .rstn(rstn), .key_i(key), .key_valid_i(kv),
      .decrypt_i(dec), .key_ready_o(kr), .rk_o(rk), .rk_idx_o(idx),
      .rk_valid_o(rv), .rk_ready_i(rr), .rk_last_o(last),
      .parity_err_o(perr)
   );

   key_schedule_seq #(.PARITY_CHECK(0)) dut0 (
      .clk(clk), .rstn(rstn), .key_i(z_key), .key_valid_i(z_kv),
      .decrypt_i(z_dec), .key_ready_o(z_kr), .rk_o(z_rk),
      .rk_idx_o(z_idx), .rk_valid_o(z_rv), .rk_ready_i(1'b1),
      .rk_last_o(z_last), .parity_err_o(z_perr)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_seq(input logic d, input int sel);
      for (int i = 0; i < 16; i++) begin
         int j;
         logic [52:0] it;
         j = d ? 15 - i : i;
         it = {ks[j], 4'(j), (i == 15)};
         if (sel == 1) q1.push_back(it);
         else q0.push_back(it);
      end
   endtask

   function automatic logic [63:0] odd_key(input logic [63:0] k);
      logic [63:0] r;
      r = k;
      for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+1 +: 7];
      return r;
   endfunction

   // Called just after a posedge; returns just after a posedge.
   task automatic start_key(input logic [63:0] k, input logic d);
      key = k;
      dec = d;
      kv = 1'b1;
      @(posedge clk); #1;
      kv = 1'b0;
   endtask

   task automatic wait_level(input int sel, input int level,
                             input logic rnd);
      int c;
      c = 0;
      while (((sel == 1) ? q1.size() : q0.size()) > level && c < 300) begin
         if (rnd) rr = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         c++;
      end
      rr = 1'b1;
      if (((sel == 1) ? q1.size() : q0.size()) > level) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: queue %0d still above %0d", sel, level);
      end
   endtask

   logic        p_stall = 1'b0;
   logic [52:0] p_val = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (p_stall && rv) check("stall_hold", 64'({rk, idx, last}),
                                  64'(p_val));
         p_stall = rv && !rr;
         p_val = {rk, idx, last};
         if (rv && rr) begin
            if (q1.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_key: got rk %h idx %0d", rk, idx);
            end else begin
               logic [52:0] e;
               e = q1.pop_front();
               check("rk_idx_last", 64'({rk, idx, last}), 64'(e));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && z_rv) begin
         if (q0.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_key0: got rk %h idx %0d", z_rk, z_idx);
         end else begin
            logic [52:0] e;
            e = q0.pop_front();
            check("rk0_idx_last", 64'({z_rk, z_idx, z_last}), 64'(e));
         end
      end
   end

   initial begin
      ks[0]  = 48'h1B02EFFC7072; ks[1]  = 48'h79AED9DBC9E5;
      ks[2]  = 48'h55FC8A42CF99; ks[3]  = 48'h72ADD6DB351D;
      ks[4]  = 48'h7CEC07EB53A8; ks[5]  = 48'h63A53E507B2F;
      ks[6]  = 48'hEC84B7F618BC; ks[7]  = 48'hF78A3AC13BFB;
      ks[8]  = 48'hE0DBEBEDE781; ks[9]  = 48'hB1F347BA464F;
      ks[10] = 48'h215FD3DED386; ks[11] = 48'h7571F59467E9;
      ks[12] = 48'h97C5D1FABA41; ks[13] = 48'h5F43B7F2E73A;
      ks[14] = 48'hBF918D3D3F0A; ks[15] = 48'hCB3D8B0E17F5;

      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(kr), 64'd1);
      check("rst_valid", 64'(rv), 64'd0);
      check("rst_last", 64'(last), 64'd0);
      check("rst_idx", 64'(idx), 64'd0);
      check("rst_rk", 64'(rk), 64'd0);
      check("rst_perr", 64'(perr), 64'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // encrypt, full rate, first key one cycle after accept
      push_seq(1'b0, 1);
      start_key(KEY, 1'b0);
      @(negedge clk);
      check("lat_valid", 64'(rv), 64'd1);
      check("lat_ready", 64'(kr), 64'd0);
      @(posedge clk); #1;
      wait_level(1, 0, 1'b0);

      // decrypt order
      push_seq(1'b1, 1);
      start_key(KEY, 1'b1);
      wait_level(1, 0, 1'b0);

      // random back-pressure
      push_seq(1'b0, 1);
      start_key(KEY, 1'b0);
      wait_level(1, 0, 1'b1);

      // even-parity byte is rejected
      start_key(KBAD, 1'b0);
      @(negedge clk);
      check("par_pulse", 64'(perr), 64'd1);
      check("par_valid", 64'(rv), 64'd0);
      check("par_ready", 64'(kr), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("par_pulse_end", 64'(perr), 64'd0);
      check("par_valid2", 64'(rv), 64'd0);
      @(posedge clk); #1;
      push_seq(1'b0, 1);
      start_key(KEY, 1'b0);
      wait_level(1, 0, 1'b0);

      // reset after the 5th handshake aborts the sequence
      for (int i = 0; i < 5; i++) q1.push_back({ks[i], 4'(i), 1'b0});
      start_key(KEY, 1'b0);
      wait_level(1, 0, 1'b0);
      rstn = 1'b1;
      rr = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      rr = 1'b1;
      @(negedge clk);
      check("abort_valid", 64'(rv), 64'd0);
      check("abort_ready", 64'(kr), 64'd1);
      @(posedge clk); #1;
      push_seq(1'b0, 1);
      start_key(KEY, 1'b0);
      wait_level(1, 0, 1'b0);

      // key_valid held high with junk keys during RUN
      push_seq(1'b0, 1);
      push_seq(1'b1, 1);
      key = KEY;
      dec = 1'b0;
      kv = 1'b1;
      @(posedge clk); #1;
      wait_junk();
      key = KEY;
      dec = 1'b1;
      @(negedge clk);
      check("b2b_ready_idle", 64'(kr), 64'd1);
      @(posedge clk); #1;
      kv = 1'b0;
      @(negedge clk);
      check("b2b_ready_run", 64'(kr), 64'd0);
      check("b2b_valid", 64'(rv), 64'd1);
      @(posedge clk); #1;
      wait_level(1, 0, 1'b0);

      // parity check disabled: parity bits ignored
      push_seq(1'b0, 0);
      z_key = KBAD;
      z_dec = 1'b0;
      z_kv = 1'b1;
      @(posedge clk); #1;
      z_kv = 1'b0;
      @(negedge clk);
      check("nopar_perr", 64'(z_perr), 64'd0);
      check("nopar_valid", 64'(z_rv), 64'd1);
      @(posedge clk); #1;
      wait_level(0, 0, 1'b0);

      repeat (3) @(posedge clk);
      check("q1_empty", 64'(q1.size()), 64'd0);
      check("q0_empty", 64'(q0.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   task automatic wait_junk();
      int c;
      c = 0;
      while (q1.size() > 16 && c < 100) begin
         key = odd_key({$urandom, $urandom});
         dec = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         c++;
      end
      if (q1.size() > 16) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: first sequence did not finish");
      end
   endtask
endmodule
